// File: rtl/bp_cfg_responder.sv
// Configuration-bus endpoint for one tile.
// Accepts commands addressed to this tile's core ID and applies writes to the
// tile control registers (freeze, start PC, cache/CCE modes). Reads return a
// register value over a valid/yumi response channel. Commands for other tiles
// are consumed and dropped.
module bp_cfg_responder #(
  parameter int unsigned cfg_core_width_p = 8,
  parameter int unsigned cfg_addr_width_p = 16,
  parameter int unsigned cfg_data_width_p = 64,
  parameter int unsigned vaddr_width_p    = 39,
  parameter logic [vaddr_width_p-1:0] npc_reset_p = 39'h00_8000_0000
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [cfg_core_width_p-1:0] my_core_id_i,

  input  logic                        cfg_v_i,
  input  logic                        cfg_w_v_i,
  input  logic [cfg_core_width_p-1:0] cfg_core_i,
  input  logic [cfg_addr_width_p-1:0] cfg_addr_i,
  input  logic [cfg_data_width_p-1:0] cfg_data_i,
  output logic                        cfg_ready_o,

  output logic                        cfg_resp_v_o,
  output logic [cfg_data_width_p-1:0] cfg_resp_data_o,
  input  logic                        cfg_resp_yumi_i,

  output logic                        freeze_o,
  output logic [vaddr_width_p-1:0]    npc_o,
  output logic                        npc_w_v_o,
  output logic                        icache_mode_o,
  output logic                        dcache_mode_o,
  output logic                        cce_mode_o
);

  // Two-state handshake FSM: READY takes commands, RESP holds a read result.
  localparam logic [0:0] READY = 1'b0;
  localparam logic [0:0] RESP  = 1'b1;

  // Register map.
  localparam logic [cfg_addr_width_p-1:0] ADDR_FREEZE  = cfg_addr_width_p'(1);
  localparam logic [cfg_addr_width_p-1:0] ADDR_NPC     = cfg_addr_width_p'(2);
  localparam logic [cfg_addr_width_p-1:0] ADDR_MODE0   = cfg_addr_width_p'(4);
  localparam logic [cfg_addr_width_p-1:0] ADDR_CORE_ID = cfg_addr_width_p'(7);
  localparam logic [cfg_addr_width_p-1:0] ADDR_CMD_CNT = cfg_addr_width_p'(8);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned N_MODES  = 3;

  logic [0:0]                  state_reg, state_next;
  logic                        accept, match, wr_hit, rd_hit;
  logic                        freeze_reg;
  logic [vaddr_width_p-1:0]    npc_reg;
  logic                        npc_w_v_reg;
  logic [N_MODES-1:0]          mode_reg;
  logic [CNT_W-1:0]            cmd_cnt_reg;
  logic [cfg_data_width_p-1:0] resp_data_reg;
  logic [cfg_data_width_p-1:0] rd_data;

  // Write data above the npc width never reaches any register.
  logic unused_data_bits;
  assign unused_data_bits = &{1'b0, cfg_data_i[cfg_data_width_p-1:vaddr_width_p]};

  assign accept = cfg_v_i & (state_reg == READY);
  assign match  = accept & (cfg_core_i == my_core_id_i);
  assign wr_hit = match & cfg_w_v_i;
  assign rd_hit = match & ~cfg_w_v_i;

  // Next state: a matching read parks in RESP until the response is consumed.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      READY:   if (rd_hit) state_next = RESP;
      RESP:    if (cfg_resp_yumi_i) state_next = READY;
      default: state_next = READY;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_reg <= READY;
    else         state_reg <= state_next;
  end

  // Read mux: unlisted addresses return zero, narrow fields are zero-extended.
  always_comb begin
    rd_data = '0;
    case (cfg_addr_i)
      ADDR_FREEZE:  rd_data[0] = freeze_reg;
      ADDR_NPC:     rd_data[vaddr_width_p-1:0] = npc_reg;
      ADDR_CORE_ID: rd_data[cfg_core_width_p-1:0] = my_core_id_i;
      ADDR_CMD_CNT: rd_data[CNT_W-1:0] = cmd_cnt_reg;
      default: begin
        for (int i = 0; i < int'(N_MODES); i++) begin
          if (cfg_addr_i == ADDR_MODE0 + cfg_addr_width_p'(i)) rd_data[0] = mode_reg[i];
        end
      end
    endcase
  end

  // Response data is captured at acceptance and held for the whole RESP state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     resp_data_reg <= '0;
    else if (rd_hit) resp_data_reg <= rd_data;
  end

  // Freeze defaults on so the core stays held until software releases it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                                freeze_reg <= 1'b1;
    else if (wr_hit && cfg_addr_i == ADDR_FREEZE) freeze_reg <= cfg_data_i[0];
  end

  // Start PC, truncated to the virtual address width.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                               npc_reg <= npc_reset_p;
    else if (wr_hit && cfg_addr_i == ADDR_NPC) npc_reg <= cfg_data_i[vaddr_width_p-1:0];
  end

  // One-cycle strobe telling the core a new start PC was written.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) npc_w_v_reg <= 1'b0;
    else         npc_w_v_reg <= wr_hit && (cfg_addr_i == ADDR_NPC);
  end

  // Mode bits live at consecutive addresses: icache, dcache, cce.
  for (genvar gi = 0; gi < int'(N_MODES); gi++) begin : g_mode
    localparam logic [cfg_addr_width_p-1:0] ADDR_THIS = ADDR_MODE0 + cfg_addr_width_p'(gi);
    // Single mode bit register.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)                                mode_reg[gi] <= 1'b0;
      else if (wr_hit && cfg_addr_i == ADDR_THIS) mode_reg[gi] <= cfg_data_i[0];
    end
  end

  // Count every matching accepted command, saturating; a read of the counter
  // sees the value from before its own increment.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                              cmd_cnt_reg <= '0;
    else if (match && cmd_cnt_reg != '1)      cmd_cnt_reg <= cmd_cnt_reg + CNT_W'(1);
  end

  assign cfg_ready_o     = (state_reg == READY);
  assign cfg_resp_v_o    = (state_reg == RESP);
  assign cfg_resp_data_o = resp_data_reg;
  assign freeze_o        = freeze_reg;
  assign npc_o           = npc_reg;
  assign npc_w_v_o       = npc_w_v_reg;
  assign icache_mode_o   = mode_reg[0];
  assign dcache_mode_o   = mode_reg[1];
  assign cce_mode_o      = mode_reg[2];

endmodule

// File: tb/tb_bp_cfg_responder.sv
// Self-checking bench for bp_cfg_responder: directed scenarios plus random
// commands checked against a register-map model held in plain variables.
module tb_bp_cfg_responder;

  localparam logic [7:0]  MY_ID   = 8'h5A;
  localparam logic [38:0] NPC_RST = 39'h00_8000_0000;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  my_core_id_i = MY_ID;
  logic        cfg_v_i = 1'b0;
  logic        cfg_w_v_i = 1'b0;
  logic [7:0]  cfg_core_i = '0;
  logic [15:0] cfg_addr_i = '0;
  logic [63:0] cfg_data_i = '0;
  logic        cfg_ready_o;
  logic        cfg_resp_v_o;
  logic [63:0] cfg_resp_data_o;
  logic        cfg_resp_yumi_i = 1'b0;
  logic        freeze_o;
  logic [38:0] npc_o;
  logic        npc_w_v_o;
  logic        icache_mode_o, dcache_mode_o, cce_mode_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic        m_freeze;
  logic [38:0] m_npc;
  logic [2:0]  m_mode;
  int unsigned m_cnt;

  bp_cfg_responder dut (
    .clk_i(clk_i), .reset_i(reset_i), .my_core_id_i(my_core_id_i),
    .cfg_v_i(cfg_v_i), .cfg_w_v_i(cfg_w_v_i), .cfg_core_i(cfg_core_i),
    .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i), .cfg_ready_o(cfg_ready_o),
    .cfg_resp_v_o(cfg_resp_v_o), .cfg_resp_data_o(cfg_resp_data_o),
    .cfg_resp_yumi_i(cfg_resp_yumi_i), .freeze_o(freeze_o), .npc_o(npc_o),
    .npc_w_v_o(npc_w_v_o), .icache_mode_o(icache_mode_o),
    .dcache_mode_o(dcache_mode_o), .cce_mode_o(cce_mode_o)
  );

  always #5 clk_i = ~clk_i;

  // Yumi while no response is pending is a protocol error.
  always @(posedge clk_i) begin
    if (cfg_resp_yumi_i && !cfg_resp_v_o) begin
      miscompares++;
      $display("FAIL yumi_in_ready: yumi=1 while resp_v=%0b, required resp_v=1", cfg_resp_v_o);
    end
  end

  function automatic void model_reset();
    m_freeze = 1'b1;
    m_npc    = NPC_RST;
    m_mode   = 3'b000;
    m_cnt    = 0;
  endfunction

  function automatic logic [63:0] model_read(input logic [15:0] a);
    logic [63:0] r;
    r = 64'd0;
    case (a)
      16'h0001: r = {63'd0, m_freeze};
      16'h0002: r = {25'd0, m_npc};
      16'h0004: r = {63'd0, m_mode[0]};
      16'h0005: r = {63'd0, m_mode[1]};
      16'h0006: r = {63'd0, m_mode[2]};
      16'h0007: r = {56'd0, MY_ID};
      16'h0008: r = 64'(m_cnt);
      default:  r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic void model_apply(input logic w, input logic [7:0] core,
                                      input logic [15:0] a, input logic [63:0] d);
    if (core == MY_ID) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (w) begin
        case (a)
          16'h0001: m_freeze = d[0];
          16'h0002: m_npc    = d[38:0];
          16'h0004: m_mode[0] = d[0];
          16'h0005: m_mode[1] = d[0];
          16'h0006: m_mode[2] = d[0];
          default: ;
        endcase
      end
    end
  endfunction

  // Bounded wait (at negedges) for the responder to take commands.
  task automatic wait_ready();
    for (int i = 0; i < 20 && !cfg_ready_o; i++) @(negedge clk_i);
    vectors++;
    if (cfg_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_timeout: cfg_ready_o=%0b, required 1", cfg_ready_o);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();
  endtask

  // Single write; returns at the negedge one cycle after acceptance.
  task automatic do_write(input logic [7:0] core, input logic [15:0] a, input logic [63:0] d);
    wait_ready();
    cfg_v_i = 1'b1; cfg_w_v_i = 1'b1; cfg_core_i = core; cfg_addr_i = a; cfg_data_i = d;
    @(posedge clk_i);
    model_apply(1'b1, core, a, d);
    @(negedge clk_i);
    cfg_v_i = 1'b0;
  endtask

  // Single read with immediate yumi; returns the sampled response.
  task automatic do_read(input logic [7:0] core, input logic [15:0] a,
                         output logic rv, output logic [63:0] rd);
    wait_ready();
    cfg_v_i = 1'b1; cfg_w_v_i = 1'b0; cfg_core_i = core; cfg_addr_i = a;
    cfg_data_i = {$urandom, $urandom};
    @(posedge clk_i);
    model_apply(1'b0, core, a, 64'd0);
    @(negedge clk_i);
    cfg_v_i = 1'b0;
    rv = cfg_resp_v_o;
    rd = cfg_resp_data_o;
    if (rv) begin
      cfg_resp_yumi_i = 1'b1;
      @(negedge clk_i);
      cfg_resp_yumi_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({freeze_o, npc_o, npc_w_v_o, icache_mode_o, dcache_mode_o, cce_mode_o} !==
        {1'b1, NPC_RST, 1'b0, 3'b000}) begin
      miscompares++;
      $display("FAIL reset_regs: freeze=%0b npc=%h npc_w_v=%0b modes=%b%b%b, required 1 %h 0 000",
               freeze_o, npc_o, npc_w_v_o, icache_mode_o, dcache_mode_o, cce_mode_o, NPC_RST);
    end
    vectors++;
    if ({cfg_ready_o, cfg_resp_v_o, cfg_resp_data_o} !== {1'b1, 1'b0, 64'd0}) begin
      miscompares++;
      $display("FAIL reset_handshake: ready=%0b resp_v=%0b data=%h, required 1 0 0",
               cfg_ready_o, cfg_resp_v_o, cfg_resp_data_o);
    end
  endtask

  task automatic test_npc();
    logic rv;
    logic [63:0] rd;
    do_write(MY_ID, 16'h0002, 64'hFFFF_FF80_0000_1234);
    vectors++;
    if (npc_o !== 39'h00_0000_1234 || npc_w_v_o !== 1'b1) begin
      miscompares++;
      $display("FAIL npc_write: npc=%h pulse=%0b, required 0000001234 1", npc_o, npc_w_v_o);
    end
    @(negedge clk_i);
    vectors++;
    if (npc_w_v_o !== 1'b0) begin
      miscompares++;
      $display("FAIL npc_pulse_width: npc_w_v=%0b, required 0", npc_w_v_o);
    end
    do_read(MY_ID, 16'h0002, rv, rd);
    vectors++;
    if (rv !== 1'b1 || rd !== 64'h0000_0000_0000_1234) begin
      miscompares++;
      $display("FAIL npc_read: resp_v=%0b data=%h, required 1 0000000000001234", rv, rd);
    end
  endtask

  task automatic test_filter();
    do_write(MY_ID + 8'd1, 16'h0001, 64'd0);
    vectors++;
    if (freeze_o !== 1'b1 || cfg_resp_v_o !== 1'b0 || cfg_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL filter_other_core: freeze=%0b resp_v=%0b ready=%0b, required 1 0 1",
               freeze_o, cfg_resp_v_o, cfg_ready_o);
    end
    do_write(MY_ID, 16'h0001, 64'd0);
    vectors++;
    if (freeze_o !== 1'b0) begin
      miscompares++;
      $display("FAIL filter_my_core: freeze=%0b, required 0", freeze_o);
    end
  endtask

  task automatic test_resp_hold();
    wait_ready();
    cfg_v_i = 1'b1; cfg_w_v_i = 1'b0; cfg_core_i = MY_ID; cfg_addr_i = 16'h0007;
    @(posedge clk_i);
    model_apply(1'b0, MY_ID, 16'h0007, 64'd0);
    @(negedge clk_i);
    cfg_v_i = 1'b1;             // keep offering a command: must not be taken
    cfg_w_v_i = 1'b1; cfg_addr_i = 16'h0001; cfg_data_i = 64'd1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (cfg_resp_v_o !== 1'b1 || cfg_resp_data_o !== {56'd0, MY_ID} || cfg_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL resp_hold[%0d]: resp_v=%0b data=%h ready=%0b, required 1 %h 0",
                 i, cfg_resp_v_o, cfg_resp_data_o, cfg_ready_o, {56'd0, MY_ID});
      end
      if (i < 4) @(negedge clk_i);
    end
    cfg_resp_yumi_i = 1'b1;
    vectors++;
    if (cfg_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL yumi_no_bypass: ready=%0b, required 0", cfg_ready_o);
    end
    cfg_v_i = 1'b0;
    @(negedge clk_i);
    cfg_resp_yumi_i = 1'b0;
    vectors++;
    if (cfg_ready_o !== 1'b1 || cfg_resp_v_o !== 1'b0 || freeze_o !== m_freeze) begin
      miscompares++;
      $display("FAIL after_yumi: ready=%0b resp_v=%0b freeze=%0b, required 1 0 %0b",
               cfg_ready_o, cfg_resp_v_o, freeze_o, m_freeze);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d [4];
    logic [15:0] a [4];
    a[0] = 16'h0004; a[1] = 16'h0005; a[2] = 16'h0006; a[3] = 16'h0002;
    wait_ready();
    for (int i = 0; i < 4; i++) begin
      d[i] = {$urandom, $urandom};
      cfg_v_i = 1'b1; cfg_w_v_i = 1'b1; cfg_core_i = MY_ID; cfg_addr_i = a[i]; cfg_data_i = d[i];
      @(posedge clk_i);
      model_apply(1'b1, MY_ID, a[i], d[i]);
      @(negedge clk_i);
      vectors++;
      if ({icache_mode_o, dcache_mode_o, cce_mode_o, npc_o} !== {m_mode[0], m_mode[1], m_mode[2], m_npc}) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: modes=%b%b%b npc=%h, required %b%b%b %h", i,
                 icache_mode_o, dcache_mode_o, cce_mode_o, npc_o, m_mode[0], m_mode[1], m_mode[2], m_npc);
      end
    end
    cfg_v_i = 1'b0;
  endtask

  task automatic test_random();
    logic rv, w, is_mine;
    logic [63:0] rd, exp, d;
    logic [15:0] a;
    logic [7:0] core;
    for (int n = 0; n < 300; n++) begin
      a = (n % 11 == 10) ? 16'($urandom) : 16'($urandom_range(0, 9));
      is_mine = ($urandom_range(0, 3) != 0);
      core = is_mine ? MY_ID : (MY_ID ^ 8'($urandom_range(1, 255)));
      w = 1'($urandom);
      d = {$urandom, $urandom};
      if (w) begin
        do_write(core, a, d);
        vectors++;
        if ({freeze_o, npc_o, icache_mode_o, dcache_mode_o, cce_mode_o, npc_w_v_o, cfg_resp_v_o} !==
            {m_freeze, m_npc, m_mode[0], m_mode[1], m_mode[2], (is_mine && a == 16'h0002), 1'b0}) begin
          miscompares++;
          $display("FAIL rand_write[%0d] core=%h addr=%h: freeze=%0b npc=%h modes=%b%b%b pulse=%0b, required %0b %h %b%b%b %0b",
                   n, core, a, freeze_o, npc_o, icache_mode_o, dcache_mode_o, cce_mode_o, npc_w_v_o,
                   m_freeze, m_npc, m_mode[0], m_mode[1], m_mode[2], (is_mine && a == 16'h0002));
        end
      end else begin
        exp = model_read(a);
        do_read(core, a, rv, rd);
        vectors++;
        if (rv !== is_mine || (is_mine && rd !== exp)) begin
          miscompares++;
          $display("FAIL rand_read[%0d] core=%h addr=%h: resp_v=%0b data=%h, required %0b %h",
                   n, core, a, rv, rd, is_mine, exp);
        end
      end
    end
  endtask

  task automatic test_cmd_cnt();
    logic rv;
    logic [63:0] rd;
    int unsigned n;
    apply_reset();
    for (int i = 0; i < 3; i++) do_write(MY_ID, 16'h0004 + 16'(i), 64'($urandom));
    do_read(MY_ID, 16'h0008, rv, rd);
    vectors++;
    if (rv !== 1'b1 || rd !== 64'd3) begin
      miscompares++;
      $display("FAIL cnt_three: resp_v=%0b data=%0d, required 1 3", rv, rd);
    end
    // Burst of writes to an unlisted address, one per cycle, up to 16'hFFFE.
    n = 65534 - m_cnt;
    wait_ready();
    cfg_v_i = 1'b1; cfg_w_v_i = 1'b1; cfg_core_i = MY_ID; cfg_addr_i = 16'h0100; cfg_data_i = 64'd0;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk_i);
      model_apply(1'b1, MY_ID, 16'h0100, 64'd0);
    end
    @(negedge clk_i);
    cfg_v_i = 1'b0;
    do_read(MY_ID, 16'h0008, rv, rd);
    vectors++;
    if (rd !== 64'h0000_0000_0000_FFFE) begin
      miscompares++;
      $display("FAIL cnt_preload: data=%h, required 000000000000fffe", rd);
    end
    do_write(MY_ID, 16'h0100, 64'd0);
    do_read(MY_ID, 16'h0008, rv, rd);
    vectors++;
    if (rd !== 64'(m_cnt) || rd !== 64'h0000_0000_0000_FFFF) begin
      miscompares++;
      $display("FAIL cnt_saturate: data=%h, required 000000000000ffff", rd);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_write(MY_ID, 16'h0001, 64'd0);
    do_write(MY_ID, 16'h0005, 64'd1);
    do_write(MY_ID, 16'h0002, 64'h0000_0012_3456_789A);
    wait_ready();
    cfg_v_i = 1'b1; cfg_w_v_i = 1'b0; cfg_core_i = MY_ID; cfg_addr_i = 16'h0002;
    @(posedge clk_i);
    @(negedge clk_i);
    cfg_v_i = 1'b0;
    vectors++;
    if (cfg_resp_v_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_resp: resp_v=%0b, required 1", cfg_resp_v_o);
    end
    #2 reset_i = 1'b1;
    #1;
    vectors++;
    if ({cfg_resp_v_o, cfg_resp_data_o, cfg_ready_o, freeze_o, npc_o, icache_mode_o, dcache_mode_o, cce_mode_o} !==
        {1'b0, 64'd0, 1'b1, 1'b1, NPC_RST, 3'b000}) begin
      miscompares++;
      $display("FAIL async_reset: resp_v=%0b data=%h ready=%0b freeze=%0b npc=%h modes=%b%b%b, required 0 0 1 1 %h 000",
               cfg_resp_v_o, cfg_resp_data_o, cfg_ready_o, freeze_o, npc_o,
               icache_mode_o, dcache_mode_o, cce_mode_o, NPC_RST);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();
    do_write(MY_ID, 16'h0001, 64'd0);
    vectors++;
    if (freeze_o !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_cmd: freeze=%0b, required 0", freeze_o);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_npc();
    test_filter();
    test_resp_hold();
    test_back_to_back();
    test_random();
    test_cmd_cnt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bp_cfg_responder.md
Name: bp_cfg_responder

Overview:
- Per-tile endpoint of the configuration bus. The bus carries core ID, address, and 64-bit data, sized by cfg_core_width / cfg_addr_width / cfg_data_width in the processor config.
- Accepts commands from the cfg initiator and filters on its own core ID.
- Writes update a small bank of tile control registers (freeze, start PC, cache/CCE modes); reads return register contents over a valid/yumi response channel.
- Sits between the cfg network link and the core/cache/CCE control inputs.

Parameters:
- cfg_core_width_p, 8, width of the core-ID field.
- cfg_addr_width_p, 16, width of the register address field.
- cfg_data_width_p, 64, width of the write and read data.
- vaddr_width_p, 39, width of the start PC (npc) register.
- npc_reset_p, 39'h00_8000_0000, reset value of npc.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- my_core_id_i  in  cfg_core_width_p  this tile's ID; quasi-static
- cfg_v_i  in  1  command valid
- cfg_w_v_i  in  1  1 = write, 0 = read
- cfg_core_i  in  cfg_core_width_p  target core ID
- cfg_addr_i  in  cfg_addr_width_p  register address
- cfg_data_i  in  cfg_data_width_p  write data
- cfg_ready_o  out  1  command accepted when cfg_v_i & cfg_ready_o
- cfg_resp_v_o  out  1  read response valid
- cfg_resp_data_o  out  cfg_data_width_p  read data
- cfg_resp_yumi_i  in  1  response consumed; legal only while cfg_resp_v_o
- freeze_o  out  1  hold core in reset-like freeze
- npc_o  out  vaddr_width_p  start PC
- npc_w_v_o  out  1  one-cycle pulse after an npc write
- icache_mode_o  out  1  0 = uncached, 1 = normal
- dcache_mode_o  out  1  0 = uncached, 1 = normal
- cce_mode_o  out  1  0 = uncached, 1 = normal

Behaviour:
- Reset (asynchronous, any state):
  - State returns to READY.
  - freeze_o=1, npc_o=npc_reset_p, npc_w_v_o=0.
  - icache_mode_o, dcache_mode_o and cce_mode_o all 0.
  - cfg_resp_v_o=0, cfg_resp_data_o=0, cmd_cnt=0.
  - A pending response is discarded.
- FSM states READY and RESP.
  - cfg_ready_o = (state==READY).
  - cfg_resp_v_o = (state==RESP).
- Command handshake:
  - A command is accepted on the cycle cfg_v_i & cfg_ready_o.
  - It targets this tile iff cfg_core_i == my_core_id_i.
  - Non-matching commands are consumed and dropped: no state change, no response, cmd_cnt unchanged.
- Matching write:
  - The register updates at the clock edge of acceptance; its output is visible the next cycle.
  - No response is generated; state stays READY, so back-to-back writes run at 1 per cycle.
- Matching read:
  - The register value is captured into cfg_resp_data_o at acceptance; state goes to RESP.
  - Latency: response valid on the cycle after acceptance.
- RESP state:
  - cfg_resp_v_o and cfg_resp_data_o are held stable until cfg_resp_yumi_i.
  - Yumi returns the FSM to READY on the next edge. There is no same-cycle bypass: cfg_ready_o=0 for the whole RESP state, including the yumi cycle.
- Register map (addresses are exact; unlisted addresses read 0 and writes are ignored but still counted):
  - 0x0001 freeze: bit 0.
  - 0x0002 npc: low vaddr_width_p bits; read zero-extended. A write pulses npc_w_v_o high for exactly one cycle (the cycle after acceptance).
  - 0x0004 icache_mode: bit 0.
  - 0x0005 dcache_mode: bit 0.
  - 0x0006 cce_mode: bit 0.
  - 0x0007 core_id: read-only, returns my_core_id_i zero-extended; writes ignored.
  - 0x0008 cmd_cnt: 16-bit read-only count of matching accepted commands, saturating at 16'hFFFF; read zero-extended.
- cmd_cnt timing: a read of cmd_cnt returns the value *before* counting that read.
- Width rules: write data is truncated to the field width; unused upper bits are ignored.
- cfg_resp_yumi_i while in READY is illegal; the bench asserts on it. The design ignores it.

Test Plan:
- Reset then idle → freeze_o=1, npc_o=39'h00_8000_0000, all modes 0, cfg_ready_o=1, cfg_resp_v_o=0.
- Write core=my_id, addr 0x0002, data 64'hFFFF_FF80_0000_1234 → next cycle npc_o=39'h00_0000_1234 (bits 38:0 of the write data), one-cycle npc_w_v_o pulse. Read 0x0002 → resp data 64'h0000_0000_0000_1234 one cycle after acceptance.
- Write 0x0001 data 0 with core=my_id+1 → freeze_o stays 1, no response. Then the same write with core=my_id → freeze_o=0 next cycle.
- Read 0x0007 with cfg_resp_yumi_i held low 5 cycles → cfg_resp_v_o=1 and data stable, cfg_ready_o=0 throughout. On yumi, cfg_ready_o=1 the following cycle.
- Three matching writes then a read of 0x0008 → data 3. Preload to 16'hFFFF via 65535 writes → a further write leaves it 16'hFFFF.
- Assert reset_i asynchronously mid-RESP → cfg_resp_v_o drops immediately, all registers return to reset values, and the next command is accepted after deassertion.
